// File: rtl/fwrisc_mem_arbiter_if.sv
// Bundle of the fetch (I), data (D) and memory-bus (M) handshake signals
// around the fwrisc memory arbiter. The slave modport is the arbiter's view;
// the master modport is the view of the surrounding core and bus fabric.
interface fwrisc_mem_arbiter_if;

    // Fetch port
    logic        ivalid;
    logic [31:0] iaddr;
    logic        iready;
    logic [31:0] irdata;
    logic        ierr;

    // Data / MEM-stage port
    logic        dvalid;
    logic [31:0] daddr;
    logic        dwrite;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        dready;
    logic [31:0] drdata;
    logic        derr;

    // Shared memory bus
    logic        mvalid;
    logic [31:0] maddr;
    logic        mwrite;
    logic [31:0] mwdata;
    logic [3:0]  mwstb;
    logic        mready;
    logic [31:0] mrdata;

    modport slave (
        input  ivalid, iaddr,
        output iready, irdata, ierr,
        input  dvalid, daddr, dwrite, dwdata, dwstb,
        output dready, drdata, derr,
        output mvalid, maddr, mwrite, mwdata, mwstb,
        input  mready, mrdata
    );

    modport master (
        output ivalid, iaddr,
        input  iready, irdata, ierr,
        output dvalid, daddr, dwrite, dwdata, dwstb,
        input  dready, drdata, derr,
        input  mvalid, maddr, mwrite, mwdata, mwstb,
        output mready, mrdata
    );

endinterface

// File: rtl/fwrisc_mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch (I) and the
// data/MEM stage (D). D has priority, a streak counter forces a fetch grant
// after MAX_D_STREAK consecutive contended D grants, and a timeout aborts an
// access whose mready never arrives. Only one bus access is ever outstanding.
//
// Arbitration happens in IDLE and in the completion cycle of an access, using
// the raw valids seen in that cycle. A requester with no further work drops
// valid in its ready cycle; a valid that is still high there is treated as
// its next request, which is what allows back-to-back accesses.
module fwrisc_mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input logic                  clock,
    input logic                  reset,
    fwrisc_mem_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam int unsigned      TMO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit               TMO_EN     = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_EN ? TMO_W'(TIMEOUT - 1) : '0;
    localparam logic [3:0]       STREAK_MAX = 4'(MAX_D_STREAK);

    logic [1:0]       state_q,  state_d;
    logic [3:0]       streak_q, streak_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic             mvalid_q, mvalid_d;
    logic [31:0]      maddr_q,  maddr_d;
    logic             mwrite_q, mwrite_d;
    logic [31:0]      mwdata_q, mwdata_d;
    logic [3:0]       mwstb_q,  mwstb_d;

    logic busy;
    logic complete;
    logic abort;
    logic can_grant;
    logic d_wins;
    logic grant_d;
    logic grant_i;

    // Completion, abort and grant decisions for the current cycle
    always_comb begin
        busy      = (state_q != ST_IDLE);
        complete  = busy && bus.mready;
        abort     = busy && !bus.mready && TMO_EN && (tmo_q == TMO_LIMIT);
        can_grant = !busy || complete;
        d_wins    = bus.dvalid && !(bus.ivalid && (streak_q == STREAK_MAX));
        grant_d   = can_grant && d_wins;
        grant_i   = can_grant && bus.ivalid && !d_wins;
    end

    // Next-state, bus payload, streak and timeout counter
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        mvalid_d = mvalid_q;
        maddr_d  = maddr_q;
        mwrite_d = mwrite_q;
        mwdata_d = mwdata_q;
        mwstb_d  = mwstb_q;
        if (grant_d) begin
            state_d  = ST_BUSY_D;
            mvalid_d = 1'b1;
            maddr_d  = bus.daddr;
            mwrite_d = bus.dwrite;
            mwdata_d = bus.dwdata;
            mwstb_d  = bus.dwrite ? bus.dwstb : 4'b0000;
            tmo_d    = '0;
            if (!bus.ivalid) begin
                streak_d = 4'd0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 4'd1;
            end
        end else if (grant_i) begin
            state_d  = ST_BUSY_I;
            mvalid_d = 1'b1;
            maddr_d  = bus.iaddr;
            mwrite_d = 1'b0;
            mwdata_d = 32'h0;
            mwstb_d  = 4'b0000;
            tmo_d    = '0;
            streak_d = 4'd0;
        end else if (complete || abort) begin
            state_d  = ST_IDLE;
            mvalid_d = 1'b0;
        end else if (busy && TMO_EN) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            streak_q <= 4'd0;
            tmo_q    <= '0;
            mvalid_q <= 1'b0;
            maddr_q  <= 32'h0;
            mwrite_q <= 1'b0;
            mwdata_q <= 32'h0;
            mwstb_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            mvalid_q <= mvalid_d;
            maddr_q  <= maddr_d;
            mwrite_q <= mwrite_d;
            mwdata_q <= mwdata_d;
            mwstb_q  <= mwstb_d;
        end
    end

    // Completion pulses back to the requesters; suppressed while in reset
    always_comb begin
        bus.iready = !reset && (state_q == ST_BUSY_I) && (complete || abort);
        bus.ierr   = !reset && (state_q == ST_BUSY_I) && abort;
        bus.irdata = (!reset && (state_q == ST_BUSY_I) && complete) ? bus.mrdata : 32'h0;
        bus.dready = !reset && (state_q == ST_BUSY_D) && (complete || abort);
        bus.derr   = !reset && (state_q == ST_BUSY_D) && abort;
        bus.drdata = (!reset && (state_q == ST_BUSY_D) && complete) ? bus.mrdata : 32'h0;
    end

    assign bus.mvalid = mvalid_q;
    assign bus.maddr  = maddr_q;
    assign bus.mwrite = mwrite_q;
    assign bus.mwdata = mwdata_q;
    assign bus.mwstb  = mwstb_q;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Self-checking bench for fwrisc_mem_arbiter: directed scenarios followed by
// randomized requester/memory traffic, all checked against a transaction-level
// model of the arbitration, streak and timeout rules.
module tb_fwrisc_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fwrisc_mem_arbiter_if bus();

    fwrisc_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Reference model: the access currently on the bus and arbitration history
    bit          m_busy   = 1'b0;
    bit          m_is_d   = 1'b0;
    int          m_wait   = 0;
    int          m_streak = 0;
    logic [31:0] m_addr   = 32'h0;
    logic        m_write  = 1'b0;
    logic [31:0] m_wdata  = 32'h0;
    logic [3:0]  m_wstb   = 4'h0;

    // Random-phase requester state
    bit          i_pend = 1'b0;
    bit          d_pend = 1'b0;
    bit          mr_r;
    bit          rst_r;
    bit          fin_r;
    logic [31:0] i_a  = 32'h0;
    logic [31:0] d_a  = 32'h0;
    logic        d_w  = 1'b0;
    logic [31:0] d_wd = 32'h0;
    logic [3:0]  d_s  = 4'h0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit rst, input bit iv, input logic [31:0] ia,
                                  input bit dv, input logic [31:0] da, input bit dw,
                                  input logic [31:0] dwd, input logic [3:0] ds,
                                  input bit mr, input logic [31:0] mrd);
        reset      = rst;
        bus.ivalid = iv;
        bus.iaddr  = ia;
        bus.dvalid = dv;
        bus.daddr  = da;
        bus.dwrite = dw;
        bus.dwdata = dwd;
        bus.dwstb  = ds;
        bus.mready = mr;
        bus.mrdata = mrd;
        #1;
    endtask

    task automatic model_check();
        bit complete;
        bit abort;
        bit done;
        complete = m_busy && bus.mready;
        abort    = m_busy && !bus.mready && (m_wait == TMO - 1);
        done     = (complete || abort) && !reset;
        check_output("mvalid", 32'(bus.mvalid), 32'(m_busy));
        if (m_busy) begin
            check_output("maddr",  bus.maddr,         m_addr);
            check_output("mwrite", 32'(bus.mwrite),   32'(m_write));
            check_output("mwdata", bus.mwdata,        m_wdata);
            check_output("mwstb",  32'(bus.mwstb),    32'(m_wstb));
        end
        check_output("iready", 32'(bus.iready), 32'(done && !m_is_d));
        check_output("dready", 32'(bus.dready), 32'(done && m_is_d));
        if (done && !m_is_d) begin
            check_output("ierr",   32'(bus.ierr), 32'(abort));
            check_output("irdata", bus.irdata,    abort ? 32'h0 : bus.mrdata);
        end
        if (done && m_is_d) begin
            check_output("derr",   32'(bus.derr), 32'(abort));
            check_output("drdata", bus.drdata,    abort ? 32'h0 : bus.mrdata);
        end
    endtask

    task automatic model_update();
        bit complete;
        bit abort;
        bit pick_d;
        if (reset) begin
            m_busy   = 1'b0;
            m_wait   = 0;
            m_streak = 0;
            m_addr   = 32'h0;
            m_write  = 1'b0;
            m_wdata  = 32'h0;
            m_wstb   = 4'h0;
            return;
        end
        complete = m_busy && bus.mready;
        abort    = m_busy && !bus.mready && (m_wait == TMO - 1);
        if ((!m_busy || complete) && (bus.dvalid || bus.ivalid)) begin
            pick_d = bus.dvalid && !(bus.ivalid && m_streak >= MAXS);
            if (pick_d) begin
                m_addr   = bus.daddr;
                m_write  = bus.dwrite;
                m_wdata  = bus.dwdata;
                m_wstb   = bus.dwrite ? bus.dwstb : 4'h0;
                m_streak = bus.ivalid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else begin
                m_addr   = bus.iaddr;
                m_write  = 1'b0;
                m_wdata  = 32'h0;
                m_wstb   = 4'h0;
                m_streak = 0;
            end
            m_busy = 1'b1;
            m_is_d = pick_d;
            m_wait = 0;
        end else if (complete || abort) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_wait++;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        model_check();
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        // Reset: first edge brings the DUT out of X before any checking
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        check_output("rst_mvalid", 32'(bus.mvalid), 32'h0);
        check_output("rst_maddr",  bus.maddr,       32'h0);
        check_output("rst_mwdata", bus.mwdata,      32'h0);
        check_output("rst_mwrite", 32'(bus.mwrite), 32'h0);
        check_output("rst_mwstb",  32'(bus.mwstb),  32'h0);
        check_output("rst_iready", 32'(bus.iready), 32'h0);
        check_output("rst_dready", 32'(bus.dready), 32'h0);
        cycle();

        // Single load, memory answers two cycles after mvalid
        $display("[TB] single load");
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
        check_output("load_mvalid_n", 32'(bus.mvalid), 32'h0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
        check_output("load_mvalid_n1", 32'(bus.mvalid), 32'h1);
        check_output("load_maddr",     bus.maddr,       32'h100);
        check_output("load_mwstb",     32'(bus.mwstb),  32'h0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF);
        check_output("load_dready", 32'(bus.dready), 32'h1);
        check_output("load_drdata", bus.drdata,      32'hDEADBEEF);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        check_output("load_mvalid_drop", 32'(bus.mvalid), 32'h0);
        cycle();

        // Store completing in its first bus cycle
        $display("[TB] store");
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h204, 1'b1, 32'h12345678, 4'b0011, 1'b0, 32'h0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h204, 1'b1, 32'h12345678, 4'b0011, 1'b1, 32'h0);
        check_output("store_mwrite", 32'(bus.mwrite), 32'h1);
        check_output("store_mwdata", bus.mwdata,      32'h12345678);
        check_output("store_mwstb",  32'(bus.mwstb),  32'h3);
        check_output("store_dready", 32'(bus.dready), 32'h1);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        cycle();

        // Contention with zero-wait memory: D,D,D,D,I repeating, bus never idle
        $display("[TB] contention");
        apply_stimulus(1'b0, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0);
        cycle();
        for (int k = 0; k <= 10; k++) begin
            logic [31:0] exp_addr;
            exp_addr = ((k % 5) == 4) ? 32'h1000 : 32'h2000;
            apply_stimulus(1'b0, (k < 10), 32'h1000, (k < 10), 32'h2000, 1'b0, 32'h0, 4'h0,
                           1'b1, $urandom);
            check_output("cont_mvalid", 32'(bus.mvalid), 32'h1);
            check_output("cont_order",  bus.maddr,       exp_addr);
            cycle();
        end
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        check_output("cont_mvalid_drop", 32'(bus.mvalid), 32'h0);
        cycle();

        // Fetch timeout: abort in the 8th busy cycle
        $display("[TB] timeout abort");
        apply_stimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        cycle();
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(1'b0, (k < 8), 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
            if (k < 8) begin
                check_output("tmo_iready_early", 32'(bus.iready), 32'h0);
            end else begin
                check_output("tmo_iready", 32'(bus.iready), 32'h1);
                check_output("tmo_ierr",   32'(bus.ierr),   32'h1);
                check_output("tmo_irdata", bus.irdata,      32'h0);
            end
            cycle();
        end
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        check_output("tmo_mvalid_drop", 32'(bus.mvalid), 32'h0);
        cycle();

        // mready arriving exactly at the timeout limit is a normal completion
        $display("[TB] completion at timeout limit");
        apply_stimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        cycle();
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(1'b0, (k < 8), 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                           (k == 8), 32'hCAFEF00D);
            if (k == 8) begin
                check_output("lim_iready", 32'(bus.iready), 32'h1);
                check_output("lim_ierr",   32'(bus.ierr),   32'h0);
                check_output("lim_irdata", bus.irdata,      32'hCAFEF00D);
            end
            cycle();
        end
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        cycle();

        // Reset while a data access is on the bus
        $display("[TB] reset mid-access");
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        cycle();
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 4'h0, 1'b1, 32'h77);
        check_output("rstmid_dready", 32'(bus.dready), 32'h0);
        cycle();
        apply_stimulus(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        check_output("rstmid_mvalid", 32'(bus.mvalid), 32'h0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h55);
        check_output("rstmid_i_maddr",  bus.maddr,       32'h500);
        check_output("rstmid_i_iready", 32'(bus.iready), 32'h1);
        cycle();

        // Stray mready while idle
        $display("[TB] stray mready");
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'hFFFF);
        check_output("stray_iready", 32'(bus.iready), 32'h0);
        check_output("stray_dready", 32'(bus.dready), 32'h0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        check_output("stray_mvalid", 32'(bus.mvalid), 32'h0);
        cycle();

        // Randomized requesters and memory latency against the model
        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            mr_r  = ($urandom_range(0, 2) == 0);
            rst_r = ($urandom_range(0, 199) == 0);
            fin_r = m_busy && !rst_r && (mr_r || (m_wait == TMO - 1));
            if (!i_pend || (fin_r && !m_is_d)) begin
                i_pend = ($urandom_range(0, 1) == 1);
                i_a    = $urandom;
            end
            if (!d_pend || (fin_r && m_is_d)) begin
                d_pend = ($urandom_range(0, 2) != 0);
                d_a    = $urandom;
                d_w    = ($urandom_range(0, 1) == 1);
                d_wd   = $urandom;
                d_s    = 4'($urandom);
            end
            apply_stimulus(rst_r, i_pend, i_a, d_pend, d_a, d_w, d_wd, d_s, mr_r, $urandom);
            cycle();
        end

        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0);
        cycle();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
